// File: rtl/pipe_reg_fd_skid.sv
// Fetch/decode pipeline register with skid FIFO, deferred flush and perf counters.
// Ports:
//   clk, rst            : clock, async active-high reset
//   in_valid/inst/pc    : fetch offer
//   in_ready            : accept when skid FIFO is not full
//   jb, stall, waiting  : flush, hazard stall, memory wait
//   out_valid/inst/pc   : registered instruction to ID
//   stall_cnt/flush_cnt : saturating event counters
module pipe_reg_fd_skid #(
    parameter int          XLEN       = 64,
    parameter int          SKID_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h00000013,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             in_ready,
    input  logic             jb,
    input  logic             stall,
    input  logic             waiting,
    output logic             out_valid,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(SKID_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(SKID_DEPTH);

    logic [31:0]     skid_inst [SKID_DEPTH];
    logic [XLEN-1:0] skid_pc   [SKID_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            pend_flush;

    logic hold;
    logic acc;
    logic nonempty;
    logic push;
    logic pop;
    logic clear;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on registered occupancy
    assign in_ready = (count < FULL);
    assign hold     = stall | waiting;
    assign acc      = in_valid & in_ready;
    assign nonempty = (count != '0);

    // Push while held (unless a flush is pending) or behind a draining skid
    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        if (jb) begin
            clear = 1'b1;
        end else if (hold) begin
            push = acc & ~pend_flush;
        end else if (pend_flush) begin
            clear = 1'b1;
        end else begin
            pop  = nonempty;
            push = acc & nonempty;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            skid_inst[wr_ptr] <= in_inst;
            skid_pc[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_inst   <= NOP_INST;
            out_pc     <= '0;
            pend_flush <= 1'b0;
        end else if (jb) begin
            // A flush under hold is remembered and applied on release
            pend_flush <= hold;
            if (!hold) begin
                out_valid <= 1'b0;
                out_inst  <= NOP_INST;
                out_pc    <= '0;
            end
        end else if (hold) begin
            pend_flush <= pend_flush;
        end else if (pend_flush) begin
            pend_flush <= 1'b0;
            out_valid  <= 1'b0;
            out_inst   <= NOP_INST;
            out_pc     <= '0;
        end else if (nonempty) begin
            out_valid <= 1'b1;
            out_inst  <= skid_inst[rd_ptr];
            out_pc    <= skid_pc[rd_ptr];
        end else if (acc) begin
            out_valid <= 1'b1;
            out_inst  <= in_inst;
            out_pc    <= in_pc;
        end else begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
            out_pc    <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hold && out_valid && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (jb && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_reg_fd_skid.sv
// Bench for pipe_reg_fd_skid: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_pipe_reg_fd_skid;

    localparam int XLEN  = 64;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam logic [31:0] NOP = 32'h00000013;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             in_ready;
    logic             jb;
    logic             stall;
    logic             waiting;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [XLEN-1:0]  out_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_reg_fd_skid #(
        .XLEN(XLEN), .SKID_DEPTH(DEPTH), .NOP_INST(NOP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
        .in_ready(in_ready),
        .jb(jb), .stall(stall), .waiting(waiting),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t          q[$];
    logic            m_valid;
    logic [31:0]     m_inst;
    logic [XLEN-1:0] m_pc;
    int              m_stall;
    int              m_flush;
    bit              m_pend;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_inst  = NOP;
        m_pc    = '0;
        m_stall = 0;
        m_flush = 0;
        m_pend  = 0;
    endtask

    task automatic bubble();
        m_valid = 1'b0;
        m_inst  = NOP;
        m_pc    = '0;
    endtask

    task automatic check_out(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, "_inst"}, 64'(out_inst), 64'(m_inst));
        chk({tag, "_pc"}, 64'(out_pc), 64'(m_pc));
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
    endtask

    function automatic logic [31:0] mk_inst(input logic [XLEN-1:0] pc);
        return 32'hA000_0000 | pc[27:0];
    endfunction

    // One cycle: drive, check readiness, advance model, clock, check outputs
    task automatic step(input string tag, input bit iv,
                        input logic [XLEN-1:0] pc, input bit j,
                        input bit st, input bit wt);
        bit   a;
        bit   h;
        entry_t e;
        in_valid = iv;
        in_pc    = pc;
        in_inst  = mk_inst(pc);
        jb       = j;
        stall    = st;
        waiting  = wt;
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
        a = iv && (q.size() < DEPTH);
        h = st || wt;
        if (h && m_valid && m_stall < CMAX) m_stall++;
        if (j && m_flush < CMAX) m_flush++;
        e.inst = mk_inst(pc);
        e.pc   = pc;
        if (j) begin
            q.delete();
            if (!h) bubble();
            m_pend = h;
        end else if (h) begin
            if (a && !m_pend) q.push_back(e);
        end else if (m_pend) begin
            q.delete();
            bubble();
            m_pend = 0;
        end else if (q.size() > 0) begin
            entry_t hd;
            hd = q.pop_front();
            m_valid = 1'b1;
            m_inst  = hd.inst;
            m_pc    = hd.pc;
            if (a) q.push_back(e);
        end else if (a) begin
            m_valid = 1'b1;
            m_inst  = e.inst;
            m_pc    = e.pc;
        end else begin
            bubble();
        end
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    logic [XLEN-1:0] rpc;

    initial begin
        rst = 1'b1;
        in_valid = 0; in_inst = '0; in_pc = '0;
        jb = 0; stall = 0; waiting = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        step("stream0", 1, 'h0, 0, 0, 0);
        chk("stream0_pc", out_pc, 'h0);
        step("stream4", 1, 'h4, 0, 0, 0);
        step("stream8", 1, 'h8, 0, 0, 0);
        chk("stream8_pc", out_pc, 'h8);

        step("cap_load", 1, 'h10, 0, 0, 0);
        step("cap_s1", 1, 'h14, 0, 1, 0);
        step("cap_s2", 1, 'h18, 0, 1, 0);
        chk("cap_full", 64'(in_ready), 64'd0);
        step("cap_s3", 1, 'h1c, 0, 1, 0);
        chk("cap_hold_pc", out_pc, 'h10);
        chk("cap_stall_cnt", 64'(stall_cnt), 64'd3);
        step("cap_r1", 1, 'h1c, 0, 0, 0);
        chk("cap_r1_pc", out_pc, 'h14);
        step("cap_r2", 1, 'h1c, 0, 0, 0);
        chk("cap_r2_pc", out_pc, 'h18);
        step("cap_r3", 0, 'h0, 0, 0, 0);
        chk("cap_r3_pc", out_pc, 'h1c);

        step("fl_fill1", 1, 'h30, 0, 1, 0);
        step("fl_fill2", 1, 'h34, 0, 1, 0);
        step("fl_jb", 0, 'h0, 1, 0, 0);
        chk("fl_inst", 64'(out_inst), 64'(NOP));
        chk("fl_empty", 64'(in_ready), 64'd1);
        step("fl_after", 0, 'h0, 0, 0, 0);

        step("df_load", 1, 'h40, 0, 0, 0);
        step("df_jb", 0, 'h0, 1, 0, 1);
        chk("df_keep", out_pc, 'h40);
        step("df_wait", 1, 'h44, 0, 0, 1);
        step("df_rel", 0, 'h0, 0, 0, 0);
        chk("df_bubble", 64'(out_valid), 64'd0);
        step("df_new", 1, 'h80, 0, 0, 0);
        chk("df_new_pc", out_pc, 'h80);

        step("pp_load", 1, 'h20, 0, 0, 0);
        step("pp_fill", 1, 'h24, 0, 1, 0);
        step("pp_both", 1, 'h28, 0, 0, 0);
        chk("pp_pc", out_pc, 'h24);
        chk("pp_ready", 64'(in_ready), 64'd1);
        step("pp_drain", 0, 'h0, 0, 0, 0);
        chk("pp_drain_pc", out_pc, 'h28);

        step("sat_load", 1, 'h90, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat_hold", 0, 'h0, 0, i[0], ~i[0]);
        chk("sat_stall", 64'(stall_cnt), 64'd15);
        step("sat_rel", 0, 'h0, 0, 0, 0);

        rpc = 'h1000;
        for (int i = 0; i < 400; i++) begin
            bit iv;
            iv = ($urandom_range(0, 3) != 0);
            step("rand", iv, rpc, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
            if (iv) rpc = rpc + 4;
        end

        step("ar_f1", 1, 'h200, 0, 1, 0);
        step("ar_f2", 1, 'h204, 0, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_out("async_rst");
        chk("async_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 0; stall = 0; waiting = 0; jb = 0;
        step("post_rst", 1, 'h300, 0, 0, 0);
        step("post_rst2", 0, 'h0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
